conv_same_reader: RTL and testbench
===================================

Name: conv_same_reader

Overview:
- Reader side of the "same"-length convolution result path.
- Once a convolution finishes, this block reads the central window of the full result memory: size_same_i samples starting at offset (sizey_i-1)>>1.
- It writes that window, compacted from address 0, into the "same" output memory.
- The control FSM launches it with a start pulse. It reports completion with a one-cycle done pulse.

Parameters:
- DATA_W, 16, width of one result sample.
- FULL_AW, 6, full-result memory address width; must hold 2*31-2 = 60.
- SAME_AW, 5, same-output memory address width; matches the 5-bit size_same field.

Ports:
- clk  input  1  system clock, rising edge.
- rstn  input  1  synchronous active-low reset, sampled on posedge clk.
- start_i  input  1  single-cycle launch request, accepted only in IDLE.
- size_same_i  input  5  number of central samples to extract (0..31).
- sizey_i  input  5  kernel length Y (0..31), used for the centring offset.
- rd_en_o  output  1  full-result memory read enable.
- rd_addr_o  output  FULL_AW  full-result memory read address.
- rd_data_i  input  DATA_W  full-result memory read data, valid the cycle after rd_en_o.
- wr_en_o  output  1  same-output memory write enable.
- wr_addr_o  output  SAME_AW  same-output memory write address.
- wr_data_o  output  DATA_W  same-output memory write data.
- busy_o  output  1  high from start acceptance until done_o.
- done_o  output  1  one-cycle completion pulse.

Behaviour:
- Reset: rstn low at a clock edge puts the FSM in IDLE and clears all internal counters and latched sizes. All outputs are 0 the following cycle. This applies mid-operation too: any read or write in flight is abandoned and no done_o is issued.
- FSM states: IDLE, READ, DRAIN, DONE.
- IDLE:
  - start_i=1 latches n=size_same_i and off=(sizey_i==0)?0:(sizey_i-1)>>1. off is a 5-bit unsigned shift, zero-extended to FULL_AW. It also clears the counter.
  - Next state is READ if n!=0, else DONE.
  - busy_o rises the cycle after start_i.
- READ:
  - rd_en_o=1, rd_addr_o=off+cnt, for cnt=0..n-1, one per cycle.
  - Transitions to DRAIN after cnt=n-1. The sum is unsigned and never overflows (max 15+30=45).
- Write pipeline:
  - rd_en_o and cnt are delayed one cycle into a valid/index stage aligned with rd_data_i.
  - On the next edge, wr_en_o=1, wr_addr_o=index and wr_data_o=rd_data_i are registered.
  - Read-to-write latency is 2 cycles, one write per cycle, no gaps.
- DRAIN: no reads. Wait until the last write has been presented (2 cycles), then go to DONE.
- DONE: done_o=1 for exactly one cycle, busy_o=0 in the same cycle, then IDLE.
- Timing for start_i sampled at edge E0:
  - Reads occupy cycles 1..n after E0.
  - Writes occupy cycles 3..n+2.
  - done_o is high in cycle n+3.
  - For n=0, done_o is high in cycle 1 with no rd_en_o or wr_en_o.
- start_i outside IDLE (READ, DRAIN or DONE) is ignored. No re-latching, no restart.
- size_same_i and sizey_i changes after acceptance have no effect on the current run.
- No flow control: both memories are assumed always ready.
- When wr_en_o=0, wr_addr_o and wr_data_o hold their last values. When rd_en_o=0, rd_addr_o=0.

Test Plan:
- sizey=5, size_same=8, memory holds full[i]=100+i:
  - rd_addr 2..9 on consecutive cycles.
  - wr_addr 0..7 with data 102..109, starting 2 cycles after the first read.
  - done_o in cycle 11 after start; busy_o high cycles 1..10.
- sizey=4, size_same=6: off=1, reads 1..6, writes 0..5 with full[1..6]. sizey=0 or 1: off=0.
- size_same=0, sizey=7: done_o the cycle after start; rd_en_o and wr_en_o never assert.
- sizey=31, size_same=31: reads 15..45 contiguous, final write at addr 30, done_o in cycle 34. Check no address wrap.
- size_same=10 run; pulse start_i with size_same=3 while in READ and again in DRAIN:
  - Ignored; exactly 10 writes and one done_o.
  - A fresh start in IDLE afterwards runs 3 writes.
- rstn low for one cycle during READ (cnt=4):
  - All outputs 0 the next cycle, no further writes, no done_o, busy_o=0.
  - A subsequent start runs normally from cnt=0.

Source files
------------

// File: rtl/conv_same_reader.sv
// Reader for the "same"-length convolution result: copies the central
// size_same_i samples of the full result memory, compacted to address 0.
module conv_same_reader #(
  parameter int DATA_W  = 16,
  parameter int FULL_AW = 6,
  parameter int SAME_AW = 5
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               start_i,
  input  logic [4:0]         size_same_i,
  input  logic [4:0]         sizey_i,
  output logic               rd_en_o,
  output logic [FULL_AW-1:0] rd_addr_o,
  input  logic [DATA_W-1:0]  rd_data_i,
  output logic               wr_en_o,
  output logic [SAME_AW-1:0] wr_addr_o,
  output logic [DATA_W-1:0]  wr_data_o,
  output logic               busy_o,
  output logic               done_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [4:0]         n_q;
  logic [4:0]         off_q;
  logic [4:0]         cnt_q;
  logic               rd_vld_q;
  logic [4:0]         idx_q;
  logic               wr_en_q;
  logic [SAME_AW-1:0] wr_addr_q;
  logic [DATA_W-1:0]  wr_data_q;

  logic               rd_en;
  logic               last_rd;

  assign last_rd = (cnt_q == n_q - 5'd1);

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk) begin
    if (!rstn) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // NOTE: every signal written here gets a default first, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    rd_en   = 1'b0;
    busy_o  = 1'b0;
    done_o  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start_i) state_d = (size_same_i != 5'd0) ? S_READ : S_DONE;
      end
      S_READ: begin
        rd_en  = 1'b1;
        busy_o = 1'b1;
        if (last_rd) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        busy_o = 1'b1;
        // Once the data stage is empty the final write is on the outputs.
        if (!rd_vld_q) state_d = S_DONE;
      end
      S_DONE: begin
        done_o  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: the write-data registers are plain flops, not a memory, so they are
  // reset too: every output must read 0 right after reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      n_q       <= '0;
      off_q     <= '0;
      cnt_q     <= '0;
      rd_vld_q  <= 1'b0;
      idx_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      if (state_q == S_IDLE && start_i) begin
        n_q   <= size_same_i;
        off_q <= (sizey_i == 5'd0) ? 5'd0 : ((sizey_i - 5'd1) >> 1);
        cnt_q <= '0;
      end else if (state_q == S_READ) begin
        cnt_q <= cnt_q + 5'd1;
      end
      // Stage 1 lines up with rd_data_i; stage 2 registers the write.
      rd_vld_q <= rd_en;
      idx_q    <= cnt_q;
      wr_en_q  <= rd_vld_q;
      if (rd_vld_q) begin
        wr_addr_q <= SAME_AW'(idx_q);
        wr_data_q <= rd_data_i;
      end
    end
  end

  assign rd_en_o   = rd_en;
  assign rd_addr_o = rd_en ? (FULL_AW'(off_q) + FULL_AW'(cnt_q)) : '0;
  assign wr_en_o   = wr_en_q;
  assign wr_addr_o = wr_addr_q;
  assign wr_data_o = wr_data_q;

endmodule

// File: tb/tb_conv_same_reader.sv
// Self-checking bench for conv_same_reader: a memory model feeds reads and a
// scoreboard of expected writes is popped as the DUT writes.
module tb_conv_same_reader;

  logic        clk;
  logic        rstn;
  logic        start_i;
  logic [4:0]  size_same_i;
  logic [4:0]  sizey_i;
  logic        rd_en_o;
  logic [5:0]  rd_addr_o;
  logic [15:0] rd_data_i;
  logic        wr_en_o;
  logic [4:0]  wr_addr_o;
  logic [15:0] wr_data_o;
  logic        busy_o;
  logic        done_o;

  int checks   = 0;
  int failures = 0;

  logic [15:0] mem [0:63];
  logic [4:0]  exp_addr_q [$];
  logic [15:0] exp_data_q [$];

  conv_same_reader #(.DATA_W(16), .FULL_AW(6), .SAME_AW(5)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .start_i     (start_i),
    .size_same_i (size_same_i),
    .sizey_i     (sizey_i),
    .rd_en_o     (rd_en_o),
    .rd_addr_o   (rd_addr_o),
    .rd_data_i   (rd_data_i),
    .wr_en_o     (wr_en_o),
    .wr_addr_o   (wr_addr_o),
    .wr_data_o   (wr_data_o),
    .busy_o      (busy_o),
    .done_o      (done_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Full-result memory: registered read, data valid the cycle after rd_en_o.
  initial rd_data_i = '0;
  always @(posedge clk) if (rd_en_o) rd_data_i <= mem[rd_addr_o];

  task automatic fill_ramp();
    for (int i = 0; i < 64; i++) mem[i] = 16'(100 + i);
  endtask

  task automatic fill_random();
    for (int i = 0; i < 64; i++) mem[i] = 16'($urandom);
  endtask

  // One launch; inj1/inj2 pulse a stray start in those cycles, rst_c pulses
  // reset in that cycle and abandons the run.
  task automatic run_op(input int n, input int sy, input int inj1, input int inj2,
                        input int rst_c);
    int off, done_c;
    logic        exp_rd, exp_wr, exp_busy, exp_done;
    logic [5:0]  exp_ra;
    logic [4:0]  ea;
    logic [15:0] ed;
    off    = (sy == 0) ? 0 : (sy - 1) / 2;
    done_c = (n == 0) ? 1 : n + 3;
    exp_addr_q.delete();
    exp_data_q.delete();
    for (int i = 0; i < n; i++) begin
      exp_addr_q.push_back(5'(i));
      exp_data_q.push_back(mem[off + i]);
    end
    @(negedge clk);
    start_i     = 1'b1;
    size_same_i = 5'(n);
    sizey_i     = 5'(sy);
    for (int c = 1; c <= done_c; c++) begin
      @(negedge clk);
      if (c == 1) begin
        size_same_i = 5'($urandom);
        sizey_i     = 5'($urandom);
      end
      exp_rd   = (c <= n);
      exp_ra   = exp_rd ? 6'(off + c - 1) : 6'd0;
      exp_wr   = (c >= 3 && c <= n + 2);
      exp_busy = (n != 0 && c <= n + 2);
      exp_done = (c == done_c);
      checks += 5;
      if (rd_en_o !== exp_rd) begin
        failures++;
        $display("FAIL rd_en n=%0d c=%0d got=%0b exp=%0b", n, c, rd_en_o, exp_rd);
      end
      if (rd_addr_o !== exp_ra) begin
        failures++;
        $display("FAIL rd_addr n=%0d c=%0d got=%0d exp=%0d", n, c, rd_addr_o, exp_ra);
      end
      if (wr_en_o !== exp_wr) begin
        failures++;
        $display("FAIL wr_en n=%0d c=%0d got=%0b exp=%0b", n, c, wr_en_o, exp_wr);
      end
      if (busy_o !== exp_busy) begin
        failures++;
        $display("FAIL busy n=%0d c=%0d got=%0b exp=%0b", n, c, busy_o, exp_busy);
      end
      if (done_o !== exp_done) begin
        failures++;
        $display("FAIL done n=%0d c=%0d got=%0b exp=%0b", n, c, done_o, exp_done);
      end
      if (wr_en_o === 1'b1) begin
        checks++;
        if (exp_addr_q.size() == 0) begin
          failures++;
          $display("FAIL wr_extra n=%0d c=%0d got_addr=%0d exp=none", n, c, wr_addr_o);
        end else begin
          ea = exp_addr_q.pop_front();
          ed = exp_data_q.pop_front();
          checks++;
          if (wr_addr_o !== ea || wr_data_o !== ed) begin
            failures++;
            $display("FAIL wr_word n=%0d c=%0d got=%0d:%0d exp=%0d:%0d",
                     n, c, wr_addr_o, wr_data_o, ea, ed);
          end
        end
      end
      if (c == rst_c) begin
        rstn    = 1'b0;
        start_i = 1'b0;
        @(negedge clk);
        checks++;
        if ({rd_en_o, rd_addr_o, wr_en_o, wr_addr_o, wr_data_o, busy_o, done_o} !== '0) begin
          failures++;
          $display("FAIL rst_outputs got=%0b/%0d/%0b/%0d/%0d/%0b/%0b exp=all_zero",
                   rd_en_o, rd_addr_o, wr_en_o, wr_addr_o, wr_data_o, busy_o, done_o);
        end
        rstn = 1'b1;
        for (int k = 0; k < 8; k++) begin
          @(negedge clk);
          checks++;
          if ({rd_en_o, wr_en_o, busy_o, done_o} !== 4'b0) begin
            failures++;
            $display("FAIL rst_quiet k=%0d got=%0b%0b%0b%0b exp=0000",
                     k, rd_en_o, wr_en_o, busy_o, done_o);
          end
        end
        exp_addr_q.delete();
        exp_data_q.delete();
        return;
      end
      start_i = (c == inj1 || c == inj2);
      if (start_i) begin
        size_same_i = 5'd3;
        sizey_i     = 5'd1;
      end
    end
    start_i = 1'b0;
    @(negedge clk);
    checks += 2;
    if ({done_o, busy_o, wr_en_o, rd_en_o} !== 4'b0) begin
      failures++;
      $display("FAIL idle_after n=%0d got=%0b%0b%0b%0b exp=0000",
               n, done_o, busy_o, wr_en_o, rd_en_o);
    end
    if (exp_addr_q.size() != 0) begin
      failures++;
      $display("FAIL wr_missing n=%0d got_left=%0d exp=0", n, exp_addr_q.size());
    end
  endtask

  task automatic test_reset();
    rstn        = 1'b0;
    start_i     = 1'b1;
    size_same_i = 5'd8;
    sizey_i     = 5'd5;
    repeat (3) @(negedge clk);
    checks++;
    if ({rd_en_o, rd_addr_o, wr_en_o, wr_addr_o, wr_data_o, busy_o, done_o} !== '0) begin
      failures++;
      $display("FAIL reset_state got=%0b/%0d/%0b/%0d/%0d/%0b/%0b exp=all_zero",
               rd_en_o, rd_addr_o, wr_en_o, wr_addr_o, wr_data_o, busy_o, done_o);
    end
    start_i = 1'b0;
    rstn    = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    fill_ramp();
    run_op(8, 5, 0, 0, 0);
  endtask

  task automatic test_offsets();
    fill_ramp();
    run_op(6, 4, 0, 0, 0);
    run_op(4, 0, 0, 0, 0);
    run_op(3, 1, 0, 0, 0);
    fill_random();
    run_op(5, 10, 0, 0, 0);
  endtask

  task automatic test_zero_len();
    run_op(0, 7, 0, 0, 0);
  endtask

  task automatic test_max();
    fill_random();
    run_op(31, 31, 0, 0, 0);
  endtask

  task automatic test_start_ignored();
    fill_ramp();
    run_op(10, 5, 4, 11, 0);
    run_op(3, 5, 0, 0, 0);
  endtask

  task automatic test_reset_mid();
    fill_ramp();
    run_op(10, 5, 0, 0, 5);
    run_op(5, 3, 0, 0, 0);
  endtask

  task automatic test_back_to_back();
    fill_random();
    run_op(2, 2, 0, 0, 0);
    run_op(1, 31, 0, 0, 0);
    run_op(7, 9, 0, 0, 0);
  endtask

  initial begin
    rstn        = 1'b0;
    start_i     = 1'b0;
    size_same_i = '0;
    sizey_i     = '0;
    test_reset();
    test_basic();
    test_offsets();
    test_zero_len();
    test_max();
    test_start_ignored();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
